// File: rtl/approx_mult_iter_if.sv
// rtl/approx_mult_iter_if.sv - operand/result handshake bundle for the iterative approximate multiplier
interface approx_mult_iter_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 out_err_nz;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_product, out_err_nz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_product, out_err_nz
  );
endinterface

// File: rtl/approx_mult_iter.sv
// rtl/approx_mult_iter.sv - iterative partial-product tree multiplier with OR-carry cells and error recovery
module approx_mult_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  approx_mult_iter_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int L  = $clog2(WIDTH);
  localparam int LW = $clog2(L + 1);
  localparam logic [LW-1:0] LAST = LW'(L - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   rows      [WIDTH];
  logic [PW-1:0]   next_rows [WIDTH];
  logic [PW-1:0]   err_acc;
  logic [PW-1:0]   lvl_err;
  logic [LW-1:0]   lvl;
  logic            approx;
  logic            recover;

  // The cell only propagates a carry one position; a carry that would
  // also collide with a set sum bit is lost and shows up in the error vector.
  function automatic logic [PW-1:0] short_carry(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return {x[PW-2:0] & y[PW-2:0], 1'b0};
  endfunction

  function automatic logic [PW-1:0] cell_sum(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return (x ^ y) | short_carry(x, y);
  endfunction

  function automatic logic [PW-1:0] cell_err(input logic [PW-1:0] x, input logic [PW-1:0] y);
    return (x ^ y) & short_carry(x, y);
  endfunction

  // Rows beyond the active count are zero, so reducing the whole bank every
  // level is harmless: zero pairs produce zero sums and zero error.
  always_comb begin
    lvl_err = '0;
    for (int k = 0; k < WIDTH; k++) begin
      next_rows[k] = '0;
    end
    for (int k = 0; k < WIDTH / 2; k++) begin
      if (approx) begin
        next_rows[k] = cell_sum(rows[2*k], rows[2*k+1]);
        lvl_err      = lvl_err + cell_err(rows[2*k], rows[2*k+1]);
      end else begin
        next_rows[k] = rows[2*k] + rows[2*k+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      err_acc         <= '0;
      lvl             <= '0;
      approx          <= 1'b0;
      recover         <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_product <= '0;
      bus.out_err_nz  <= 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        rows[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            approx       <= (bus.in_mode != 2'd0);
            recover      <= (bus.in_mode == 2'd2);
            err_acc      <= '0;
            lvl          <= '0;
            bus.in_ready <= 1'b0;
            state        <= REDUCE;
            for (int j = 0; j < WIDTH; j++) begin
              rows[j] <= bus.in_b[j] ? (PW'(bus.in_a) << j) : '0;
            end
          end
        end
        REDUCE: begin
          for (int j = 0; j < WIDTH; j++) begin
            rows[j] <= next_rows[j];
          end
          err_acc <= err_acc + lvl_err;
          lvl     <= lvl + 1'b1;
          if (lvl == LAST) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          bus.out_product <= recover ? (rows[0] + err_acc) : rows[0];
          bus.out_err_nz  <= (err_acc != '0);
          bus.out_valid   <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_approx_mult_iter.sv
// tb/tb_approx_mult_iter.sv - scoreboard bench for approx_mult_iter at WIDTH 4, 8 and 16
module tb_approx_mult_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_mult_iter_if #(.WIDTH(4))  b4 ();
  approx_mult_iter_if #(.WIDTH(8))  b8 ();
  approx_mult_iter_if #(.WIDTH(16)) b16 ();

  approx_mult_iter #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  approx_mult_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  approx_mult_iter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    logic [63:0] prod;
    logic        nz;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t q16[$];
  exp_t e4, e8, e16;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bit-serial reference of the reduction tree, written per bit position.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] m, output logic [63:0] p, output logic nz);
    logic [63:0] r [32];
    logic [63:0] mask, x, y, s, e, err;
    logic        cin;
    int          n;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    for (int j = 0; j < 32; j++) begin
      r[j] = (j < w && b[j]) ? ((64'(a) << j) & mask) : 64'd0;
    end
    n   = w;
    err = 64'd0;
    while (n > 1) begin
      for (int k = 0; k < n / 2; k++) begin
        x = r[2*k];
        y = r[2*k+1];
        s = 64'd0;
        e = 64'd0;
        if (m == 2'd0) begin
          s = (x + y) & mask;
        end else begin
          for (int i = 0; i < 2 * w; i++) begin
            cin = 1'b0;
            if (i > 0) cin = x[i-1] & y[i-1];
            s[i] = (x[i] ^ y[i]) | cin;
            e[i] = (x[i] ^ y[i]) & cin;
          end
        end
        r[k] = s;
        err  = (err + e) & mask;
      end
      n = n / 2;
    end
    p  = (m == 2'd2) ? ((r[0] + err) & mask) : r[0];
    nz = (err != 64'd0);
  endfunction

  function automatic exp_t expect_of(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] m);
    exp_t        r;
    logic [63:0] p;
    logic        nz;
    model(w, a, b, m, p, nz);
    r.prod = (m == 2'd0 || m == 2'd2) ? (64'(a) * 64'(b)) : p;
    r.nz   = nz;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) check("unexpected_out4", 64'd1, 64'd0);
      else begin
        e4 = q4.pop_front();
        check("product4", 64'(b4.out_product), e4.prod);
        check("err_nz4", 64'(b4.out_err_nz), 64'(e4.nz));
      end
    end
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) check("unexpected_out8", 64'd1, 64'd0);
      else begin
        e8 = q8.pop_front();
        check("product8", 64'(b8.out_product), e8.prod);
        check("err_nz8", 64'(b8.out_err_nz), 64'(e8.nz));
      end
    end
    if (!rst && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) check("unexpected_out16", 64'd1, 64'd0);
      else begin
        e16 = q16.pop_front();
        check("product16", 64'(b16.out_product), e16.prod);
        check("err_nz16", 64'(b16.out_err_nz), 64'(e16.nz));
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic push, input logic [15:0] ep, input logic enz);
    exp_t r;
    int   guard = 0;
    while (!b8.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!b8.in_ready) check("issue8_timeout", 64'd0, 64'd1);
    b8.in_a     = a;
    b8.in_b     = b;
    b8.in_mode  = m;
    b8.in_valid = 1'b1;
    r.prod = 64'(ep);
    r.nz   = enz;
    if (push) q8.push_back(r);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 1;
    while (!b8.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue_all(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int guard = 0;
    while (!(b4.in_ready && b8.in_ready && b16.in_ready) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!(b4.in_ready && b8.in_ready && b16.in_ready)) check("issue_all_timeout", 64'd0, 64'd1);
    q4.push_back(expect_of(4, a & 32'hF, b & 32'hF, m));
    q8.push_back(expect_of(8, a & 32'hFF, b & 32'hFF, m));
    q16.push_back(expect_of(16, a & 32'hFFFF, b & 32'hFFFF, m));
    b4.in_a  = a[3:0];  b4.in_b  = b[3:0];  b4.in_mode  = m; b4.in_valid  = 1'b1;
    b8.in_a  = a[7:0];  b8.in_b  = b[7:0];  b8.in_mode  = m; b8.in_valid  = 1'b1;
    b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_mode = m; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid  = 1'b0;
    b8.in_valid  = 1'b0;
    b16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q4.size() != 0 || q8.size() != 0 || q16.size() != 0 ||
            !(b4.in_ready && b8.in_ready && b16.in_ready)) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", 64'(q4.size() + q8.size() + q16.size()), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] ra, rb;
    logic [1:0]  rm;
    b4.in_valid = 1'b0;  b4.in_a = '0;  b4.in_b = '0;  b4.in_mode = '0;  b4.out_ready = 1'b1;
    b8.in_valid = 1'b0;  b8.in_a = '0;  b8.in_b = '0;  b8.in_mode = '0;  b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_mode = '0; b16.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(b8.in_ready), 64'd1);
    check("reset_out_valid", 64'(b8.out_valid), 64'd0);
    check("reset_product", 64'(b8.out_product), 64'd0);
    check("reset_err_nz", 64'(b8.out_err_nz), 64'd0);

    // Exact mode, full-scale operands, latency measured from the accept edge.
    issue8(8'd255, 8'd255, 2'd0, 1'b1, 16'd65025, 1'b0);
    check("busy_in_ready", 64'(b8.in_ready), 64'd0);
    wait_valid8(lat);
    check("latency_mode0", 64'(lat), 64'd5);
    drain();

    issue8(8'd3, 8'd3, 2'd1, 1'b1, 16'd5, 1'b1);
    issue8(8'd3, 8'd3, 2'd2, 1'b1, 16'd9, 1'b1);
    issue8(8'd3, 8'd3, 2'd3, 1'b1, 16'd5, 1'b1);
    issue8(8'd3, 8'd1, 2'd1, 1'b1, 16'd3, 1'b0);
    issue8(8'd0, 8'hA5, 2'd1, 1'b1, 16'd0, 1'b0);
    drain();

    // Backpressure with ignored in_valid while the result is held.
    b8.out_ready = 1'b0;
    issue8(8'd3, 8'd3, 2'd2, 1'b1, 16'd9, 1'b1);
    wait_valid8(lat);
    check("latency_mode2", 64'(lat), 64'd5);
    for (int i = 0; i < 7; i++) begin
      b8.in_valid = 1'b1;
      b8.in_a     = 8'($urandom);
      b8.in_b     = 8'($urandom);
      b8.in_mode  = 2'd0;
      @(posedge clk); #1;
      check("bp_product", 64'(b8.out_product), 64'd9);
      check("bp_err_nz", 64'(b8.out_err_nz), 64'd1);
      check("bp_out_valid", 64'(b8.out_valid), 64'd1);
      check("bp_in_ready", 64'(b8.in_ready), 64'd0);
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    check("bp_release_valid", 64'(b8.out_valid), 64'd0);
    check("bp_release_ready", 64'(b8.in_ready), 64'd1);
    b8.out_ready = 1'b1;
    issue8(8'd12, 8'd13, 2'd0, 1'b1, 16'd156, 1'b0);
    drain();

    // Reset two cycles into a transaction discards it.
    issue8(8'd255, 8'd255, 2'd1, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(b8.in_ready), 64'd1);
    check("rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("rst_product", 64'(b8.out_product), 64'd0);
    check("rst_err_nz", 64'(b8.out_err_nz), 64'd0);
    repeat (8) @(posedge clk);
    #1 check("rst_no_output", 64'(b8.out_valid), 64'd0);
    q8.push_back(expect_of(8, 32'd200, 32'd100, 2'd2));
    check("rst_followup_expect", q8[0].prod, 64'd20000);
    issue8(8'd200, 8'd100, 2'd2, 1'b0, 16'd0, 1'b0);
    drain();

    for (int t = 0; t < 3000; t++) begin
      ra = $urandom;
      rb = $urandom;
      rm = 2'($urandom_range(0, 3));
      if (t % 16 == 0) ra = 32'hFFFF_FFFF;
      if (t % 16 == 1) rb = 32'hFFFF_FFFF;
      if (t % 16 == 2) rb = 32'd0;
      issue_all(ra, rb, rm);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
